// File: rtl/factory_test_pkg.sv
// Shared definitions for the second-generation factory test tile.
//
// Contents:
//   mode_e               - encodings of the ui_in[2:1] mode field
//   UI_*                 - bit positions of the control fields in ui_in
//   LFSR_TAPS_8..32      - maximal-length Galois (right-shifting) tap masks
//   default_lfsr_taps()  - picks the matching default tap mask for a width
package factory_test_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_SHIFT = 2'd3
    } mode_e;

    // Control field positions inside ui_in
    localparam int UI_OE_EN     = 0;
    localparam int UI_MODE_LO   = 1;
    localparam int UI_MODE_HI   = 2;
    localparam int UI_DIR_SDATA = 3;
    localparam int UI_LOAD      = 4;
    localparam int UI_PRESC_LO  = 5;
    localparam int UI_PRESC_HI  = 7;

    // Galois masks: MSB set, taps listed as polynomial exponents
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;          // 8,6,5,4
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;       // 16,14,13,11
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;     // 24,23,22,17
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;   // 32,22,2,1

    // Default tap mask for a register width; widths without a table entry
    // fall back to the 8-bit mask and must be overridden by the user.
    function automatic logic [31:0] default_lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            16:      taps = 32'(LFSR_TAPS_16);
            24:      taps = 32'(LFSR_TAPS_24);
            32:      taps = LFSR_TAPS_32;
            default: taps = 32'(LFSR_TAPS_8);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/tt_reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts synchronously.
// Reusable by any tile project that needs a clean internal reset.
//
// Parameters:
//   STAGES      - number of flops in the chain (1..4); rst_sync_n rises
//                 STAGES rising clock edges after rst_n rises
// Ports:
//   clk         - clock
//   rst_n       - raw asynchronous active-low reset
//   rst_sync_n  - synchronised active-low reset
module tt_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;

    // Constant one enters stage 0 and ripples toward the output
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = 1'b1;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign rst_sync_n = sync_reg[STAGES-1];

endmodule

// File: rtl/factory_test_gen2.sv
// Second-generation factory test user module for the mux tile.
// Selects between pin loopback, an up/down counter, a Galois LFSR and a
// serial shift register, each advancing at a programmable prescaled rate
// and loadable from the bidirectional pins.
//
// Parameters:
//   CNT_WIDTH   - width of the counter, LFSR and shift register (8..32)
//   LFSR_TAPS   - Galois feedback mask, bit CNT_WIDTH-1 must be set
//   SYNC_STAGES - depth of the reset deassertion synchroniser (1..4)
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   ena         - tile powered indicator (not used)
//   ui_in       - [0] oe_en, [2:1] mode, [3] dir/sdata, [4] load,
//                 [7:5] prescale exponent P
//   uo_out      - observation byte
//   uio_in      - bidirectional pin inputs (load data, loopback source)
//   uio_out     - bidirectional pin outputs
//   uio_oe      - bidirectional pin drive enables (1 = drive)
module factory_test_gen2
    import factory_test_pkg::*;
#(
    parameter int                   CNT_WIDTH   = 8,
    parameter logic [CNT_WIDTH-1:0] LFSR_TAPS   = CNT_WIDTH'(default_lfsr_taps(CNT_WIDTH)),
    parameter int                   SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ------------------------------------------------------------------
    // Control field decode
    // ------------------------------------------------------------------
    mode_e       mode;
    logic        oe_en;
    logic        dir_sdata;
    logic        load;
    logic [2:0]  presc_exp;

    assign mode      = mode_e'(ui_in[UI_MODE_HI:UI_MODE_LO]);
    assign oe_en     = ui_in[UI_OE_EN];
    assign dir_sdata = ui_in[UI_DIR_SDATA];
    assign load      = ui_in[UI_LOAD];
    assign presc_exp = ui_in[UI_PRESC_HI:UI_PRESC_LO];

    logic unused_ena;
    assign unused_ena = ena;

    // ------------------------------------------------------------------
    // Internal reset
    // ------------------------------------------------------------------
    logic rst_sync_n;
    logic rst_i;

    tt_reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    assign rst_i = ~rst_sync_n;

    // ------------------------------------------------------------------
    // Prescaler: tick when the low P bits are all ones. With P = 0 the
    // mask is empty, so the compare is always true and every cycle ticks.
    // ------------------------------------------------------------------
    logic [7:0] prescaler_reg;
    logic [7:0] prescaler_next;
    logic [7:0] presc_mask;
    logic       tick;

    assign presc_mask     = (8'd1 << presc_exp) - 8'd1;
    assign tick           = ((prescaler_reg & presc_mask) == presc_mask);
    assign prescaler_next = prescaler_reg + 8'd1;

    // ------------------------------------------------------------------
    // Mode registers: only the selected one moves, load beats tick
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_reg,   cnt_next;
    logic [CNT_WIDTH-1:0] lfsr_reg,  lfsr_next;
    logic [CNT_WIDTH-1:0] shreg_reg, shreg_next;
    logic [CNT_WIDTH-1:0] load_val;

    assign load_val = CNT_WIDTH'(uio_in);

    always_comb begin
        cnt_next   = cnt_reg;
        lfsr_next  = lfsr_reg;
        shreg_next = shreg_reg;
        case (mode)
            MODE_COUNT: begin
                if (load) begin
                    cnt_next = load_val;
                end else if (tick) begin
                    cnt_next = dir_sdata ? cnt_reg - 1'b1 : cnt_reg + 1'b1;
                end
            end
            MODE_LFSR: begin
                if (load) begin
                    // An all-zero state would lock the LFSR forever
                    lfsr_next = (uio_in == 8'd0) ? CNT_WIDTH'(1) : load_val;
                end else if (tick) begin
                    lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
                end
            end
            MODE_SHIFT: begin
                if (load) begin
                    shreg_next = load_val;
                end else if (tick) begin
                    shreg_next = {shreg_reg[CNT_WIDTH-2:0], dir_sdata};
                end
            end
            default: begin
                // Loopback holds all state
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            prescaler_reg <= '0;
            cnt_reg       <= '0;
            lfsr_reg      <= CNT_WIDTH'(1);
            shreg_reg     <= '0;
        end else begin
            prescaler_reg <= prescaler_next;
            cnt_reg       <= cnt_next;
            lfsr_reg      <= lfsr_next;
            shreg_reg     <= shreg_next;
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] sel_reg;

    always_comb begin
        case (mode)
            MODE_LFSR:  sel_reg = lfsr_reg;
            MODE_SHIFT: sel_reg = shreg_reg;
            default:    sel_reg = cnt_reg;
        endcase
    end

    always_comb begin
        // Raw rst_n (not rst_i) makes uo_out transparent the moment the
        // reset pin goes low, which is what the IO continuity check wants.
        if (!rst_n) begin
            uo_out = ui_in;
        end else if (mode == MODE_LOOP) begin
            uo_out = uio_in;
        end else begin
            uo_out = sel_reg[7:0];
        end

        if (rst_i) begin
            uio_out = 8'd0;
        end else if (mode == MODE_LOOP) begin
            uio_out = ui_in;
        end else begin
            uio_out = sel_reg[CNT_WIDTH-1 -: 8];
        end

        // Loading reads the pins, so never fight the external driver then
        uio_oe = (!rst_i && oe_en && !load) ? 8'hFF : 8'h00;
    end

endmodule

// File: tb/tb_factory_test_gen2.sv
// Self-checking bench for factory_test_gen2 (CNT_WIDTH = 8, taps 8'hB8,
// SYNC_STAGES = 2). A behavioural model tracks the registers with plain
// integer arithmetic and predicts every output.
module tb_factory_test_gen2;

    localparam int SS   = 2;
    localparam int TAPS = 'hB8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    factory_test_gen2 #(
        .CNT_WIDTH   (8),
        .LFSR_TAPS   (8'hB8),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Reference model state
    int cnt_m, lfsr_m, sh_m, pre_m, rel_m;
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] e_uo, e_io, e_oe;

    task automatic model_reset();
        cnt_m = 0; lfsr_m = 1; sh_m = 0; pre_m = 0; rel_m = 0;
    endtask

    // Apply one rising edge to the model using the current inputs
    task automatic model_edge();
        int mode, p;
        bit tk;
        mode = int'(ui_in[2:1]);
        p    = int'(ui_in[7:5]);
        if (!rst_n) return;
        if (rel_m < SS) begin
            rel_m++;
            return;
        end
        tk    = ((pre_m % (1 << p)) == ((1 << p) - 1));
        pre_m = (pre_m + 1) % 256;
        if (ui_in[4]) begin
            if (mode == 1) cnt_m = int'(uio_in);
            if (mode == 2) lfsr_m = (uio_in == 8'd0) ? 1 : int'(uio_in);
            if (mode == 3) sh_m = int'(uio_in);
        end else if (tk) begin
            if (mode == 1) cnt_m = ui_in[3] ? (cnt_m + 255) % 256 : (cnt_m + 1) % 256;
            if (mode == 2) lfsr_m = (lfsr_m / 2) ^ (((lfsr_m % 2) == 1) ? TAPS : 0);
            if (mode == 3) sh_m = (sh_m * 2 + int'(ui_in[3])) % 256;
        end
    endtask

    task automatic model_outputs();
        int mode, r;
        mode = int'(ui_in[2:1]);
        r = (mode == 1) ? cnt_m : (mode == 2) ? lfsr_m : sh_m;
        if (!rst_n) begin
            e_uo = ui_in; e_io = 8'h00; e_oe = 8'h00;
        end else begin
            e_uo = (mode == 0) ? uio_in : 8'(r);
            e_io = (rel_m < SS) ? 8'h00 : ((mode == 0) ? ui_in : 8'(r));
            e_oe = (rel_m >= SS && ui_in[0] && !ui_in[4]) ? 8'hFF : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h5A; uio_in = 8'h3C;
        model_reset();
        #1;
        n_vec++;
        if (uo_out !== 8'h5A || uio_oe !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_transparent uo_out=%h uio_oe=%h expected 5a 00", uo_out, uio_oe);
        end
        repeat (3) @(negedge clk);
        ui_in = 8'h03;
        rst_n = 1'b1;
        #1;
        model_outputs(); n_vec++;
        if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
            n_bad++;
            $display("FAIL reset_release uo=%h uio=%h oe=%h expected %h %h %h", uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
        end
        for (int i = 0; i < SS + 3; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL reset_sync edge %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
            if (i == SS - 1) begin
                n_vec++;
                if (uo_out !== 8'h00 || uio_oe !== 8'hFF) begin
                    n_bad++;
                    $display("FAIL reset_first_active uo=%h oe=%h expected 00 ff", uo_out, uio_oe);
                end
            end
            if (i == SS) begin
                n_vec++;
                if (uo_out !== 8'h01) begin
                    n_bad++;
                    $display("FAIL reset_first_increment uo=%h expected 01", uo_out);
                end
            end
        end
    endtask

    task automatic test_count();
        ui_in = 8'h13; uio_in = 8'h00;
        step();
        ui_in = 8'h03;
        for (int i = 0; i < 256; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL count_up cyc %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
        n_vec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL count_wrap256 uo=%h uio=%h expected 00 00", uo_out, uio_out);
        end
        ui_in = 8'h0B;
        step();
        n_vec++;
        if (uo_out !== 8'hFF || uio_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL count_down_wrap uo=%h uio=%h expected ff ff", uo_out, uio_out);
        end
    endtask

    task automatic test_prescale();
        int extra;
        ui_in = 8'h13; uio_in = 8'h00;
        step();
        ui_in = 8'h63;
        for (int i = 0; i < 48; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL prescale_p3 cyc %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
        n_vec++;
        if (uo_out !== 8'h06) begin
            n_bad++;
            $display("FAIL prescale_48cyc uo=%h expected 06", uo_out);
        end
        extra = $urandom_range(0, 7);
        repeat (extra) step();
        ui_in = 8'h03;
        for (int i = 0; i < 12; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL prescale_switch cyc %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
    endtask

    task automatic test_lfsr();
        int ret;
        ret = -1;
        ui_in = 8'h15; uio_in = 8'h00;
        step();
        n_vec++;
        if (uo_out !== 8'h01) begin
            n_bad++;
            $display("FAIL lfsr_zero_load uo=%h expected 01", uo_out);
        end
        ui_in = 8'h05;
        for (int i = 0; i < 255; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe || uo_out === 8'h00) begin
                n_bad++;
                $display("FAIL lfsr_step %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
            if (uo_out === 8'h01 && ret < 0) ret = i + 1;
        end
        n_vec++;
        if (ret != 255) begin
            n_bad++;
            $display("FAIL lfsr_period got %0d expected 255", ret);
        end
    endtask

    task automatic test_shift();
        logic [3:0] pat;
        pat = 4'b1011;
        ui_in = 8'h17; uio_in = 8'h00;
        #1;
        n_vec++;
        if (uio_oe !== 8'h00) begin
            n_bad++;
            $display("FAIL shift_load_oe uio_oe=%h expected 00", uio_oe);
        end
        step();
        for (int i = 3; i >= 0; i--) begin
            ui_in = 8'h07 | (8'(pat[i]) << 3);
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL shift_bit %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
        n_vec++;
        if (uo_out !== 8'h0B) begin
            n_bad++;
            $display("FAIL shift_pattern uo=%h expected 0b", uo_out);
        end
    endtask

    task automatic test_loop();
        logic [7:0] r;
        logic [7:0] exp_uo;
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            ui_in = (r & 8'hE8) | 8'h01;
            uio_in = 8'($urandom);
            #1;
            n_vec++;
            if (uio_out !== ui_in || uo_out !== uio_in || uio_oe !== 8'hFF) begin
                n_bad++;
                $display("FAIL loop %0d uo=%h uio=%h oe=%h expected %h %h ff", i, uo_out, uio_out, uio_oe, uio_in, ui_in);
            end
            step();
        end
        // Put non-reset values into all three registers
        ui_in = 8'h13; uio_in = 8'hA5; step();
        ui_in = 8'h15; uio_in = 8'h5A; step();
        ui_in = 8'h17; uio_in = 8'h3C; step();
        ui_in = 8'h03;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        model_outputs(); n_vec++;
        if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
            n_bad++;
            $display("FAIL async_reset uo=%h uio=%h oe=%h expected %h %h %h", uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            ui_in = 8'(m * 2 + 1);
            #1;
            exp_uo = (m == 2) ? 8'h01 : 8'h00;
            n_vec++;
            if (uo_out !== exp_uo || uio_out !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_cleared mode %0d uo=%h uio=%h expected %h 00", m, uo_out, uio_out, exp_uo);
            end
        end
        for (int i = 0; i < SS + 2; i++) begin
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL reset_resync %0d uo=%h uio=%h oe=%h expected %h %h %h", i, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom);
            r[4] = ($urandom_range(0, 7) == 0);
            r[7:5] = 3'($urandom_range(0, 3));
            ui_in = r;
            uio_in = 8'($urandom);
            #1;
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL random_comb %0d ui=%h uo=%h uio=%h oe=%h expected %h %h %h", i, ui_in, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
            step();
            model_outputs(); n_vec++;
            if (uo_out !== e_uo || uio_out !== e_io || uio_oe !== e_oe) begin
                n_bad++;
                $display("FAIL random_edge %0d ui=%h uo=%h uio=%h oe=%h expected %h %h %h", i, ui_in, uo_out, uio_out, uio_oe, e_uo, e_io, e_oe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_prescale();
        test_lfsr();
        test_shift();
        test_loop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/factory_test_gen2.md
# factory_test_gen2

Parametrised second-generation factory test user module for the mux tile. It selects, via dedicated inputs, between pin loopback, an up/down counter of configurable width, a Galois LFSR and a serial shift register. Each mode runs at a programmable prescaled rate and can be loaded from the bidirectional pins. It sits directly behind the tile mux in place of a user project and is used for bring-up, IO continuity and clock/reset checks.

## Interface
Parameters:
- CNT_WIDTH, 8: width of the counter, LFSR and shift registers; legal range 8..32.
- LFSR_TAPS, 8'hB8: Galois feedback mask, CNT_WIDTH bits wide; bit CNT_WIDTH-1 must be set.
- SYNC_STAGES, 2: depth of the reset deassertion synchroniser; legal range 1..4.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: tile powered indicator; unused.
- ui_in, input, 8: control bits.
  - [0] oe_en.
  - [2:1] mode: 0 loop, 1 count, 2 lfsr, 3 shift.
  - [3] dir/sdata: count direction (1 = down) or serial data in.
  - [4] load.
  - [7:5] prescale exponent P.
- uo_out, output, 8: observation byte.
- uio_in, input, 8: bidirectional pins, input path.
- uio_out, output, 8: bidirectional pins, output path.
- uio_oe, output, 8: bidirectional pins, enable path (1 = drive).

## Operation
- Internal reset rst_i:
  - Asserts asynchronously with rst_n low.
  - Deasserts SYNC_STAGES rising edges after rst_n rises.
  - Clears all registers below.
- Reset values:
  - cnt = 0, lfsr = 1, shreg = 0, prescaler = 0.
  - uio_oe = 0, uio_out = 0.
  - uo_out = ui_in (combinational; gated on raw rst_n, not rst_i).
- Prescaler: free-running 8-bit counter. tick = 1 when P = 0; otherwise tick = 1 when prescaler[P-1:0] is all ones.
- Only the register belonging to the selected mode updates. The others hold their value across mode changes.
- load = 1: the selected register loads {zero-extend, uio_in} on every clock edge.
  - load has priority over tick.
  - LFSR load of all zeros stores 1 (lockup guard).
- On tick with load = 0:
  - count: cnt ± 1 modulo 2^CNT_WIDTH; wraps 0 -> all ones when counting down.
  - lfsr: Galois step, lfsr = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - shift: shreg = {shreg[CNT_WIDTH-2:0], sdata}.
  - loop: no state change.
- Outputs (when rst_n high), with R = the selected register:
  - loop: uo_out = uio_in; uio_out = ui_in.
  - other modes: uo_out = R[7:0]; uio_out = R[CNT_WIDTH-1 -: 8].
  - uio_oe = 8'hFF iff rst_i deasserted, oe_en = 1 and load = 0; otherwise 0. Load always reads the pins undriven.
  - uio_out is 0 while rst_i is asserted.

## Timing
- Register updates are visible on uo_out/uio_out on the same edge they occur: 1 cycle after the tick cycle, since outputs are combinational from registers.
- Timing of the first counter increment:
  - P = 0: rst_n rises before edge 0, rst_i clears at edge SYNC_STAGES-1, first increment at edge SYNC_STAGES.
  - P > 0: prescaler restarts at 0, first tick after 2^P cycles.
- Mode switch: output mux changes combinationally. The new register first advances on the next tick.
- Changing P mid-run does not reset the prescaler. The next tick occurs at the next all-ones match of the low P bits.
- rst_n low mid-operation: all state clears immediately and uo_out follows ui_in in the same cycle.
- Input changes within a cycle take effect at the next edge. There is no input synchronisation; ui_in is assumed quasi-static.

## Structure
- Package factory_test_pkg contains:
  - Mode encodings MODE_LOOP/COUNT/LFSR/SHIFT.
  - ui_in bit-index constants.
  - Default LFSR tap constants for widths 8/16/24/32.
- Sub-module tt_reset_sync (parameter STAGES): async-assert, sync-deassert synchroniser. It is reusable by other tile projects.
- Top level holds the prescaler, the three mode registers and the output mux.

## Test plan
- Reset/transparency: rst_n = 0, ui_in = 8'h5A -> uo_out = 8'h5A, uio_oe = 0. Release rst_n -> count starts SYNC_STAGES cycles later.
- Count with P = 0, mode = 1, oe_en = 1, CNT_WIDTH = 8:
  - After 256 cycles cnt returns to 0.
  - With dir = 1 and starting from 0 -> 8'hFF after 1 cycle.
  - uio_out equals uo_out.
- Prescale P = 3: count increments exactly every 8 cycles. Switching P to 0 mid-run causes no lost or doubled step beyond the defined rule.
- LFSR with taps 8'hB8 from seed 1: period 255, no zero state. Load of 8'h00 -> state 1.
- Shift: load 8'h00, then sdata pattern 1,0,1,1 with P = 0 -> uo_out = 8'h0B. With load = 1, uio_oe = 0 regardless of oe_en.
- Loop mode with oe_en = 1: uio_out = ui_in, uo_out = uio_in. Mid-run async reset clears cnt/shreg to 0 and lfsr to 1.
